// File: rtl/fir_decimator.sv
// Boxcar decimator for the FIR output stream: averages every DECIM valid samples
// and queues the results in a small FIFO behind a valid/ready interface.
module fir_decimator #(
    parameter int DATA_W     = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SHIFT-1:0] LAST_PHASE = SHIFT'(DECIM - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [SHIFT-1:0]        phase;
    logic                    block_done;
    logic                    do_push;
    logic                    do_pop;
    logic                    full;
    logic                    drop;
    logic [DATA_W-1:0]       push_data;
    logic [DATA_W-1:0]       head_next;
    logic [DATA_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        rd_ptr_next;
    logic [CNT_W-1:0]        count;

    assign sum        = acc + {{SHIFT{x_in[DATA_W-1]}}, x_in};
    assign block_done = in_valid && !flush && (phase == LAST_PHASE);
    // Taking the top DATA_W bits of the sum is the arithmetic shift by log2(DECIM).
    assign push_data  = sum[ACC_W-1:SHIFT];

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign out_valid   = (count != '0);
    assign do_pop      = out_valid && out_ready;
    assign do_push     = block_done && (!full || do_pop);
    assign drop        = block_done && full && !do_pop;
    assign rd_ptr_next = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            phase <= '0;
        end else if (flush || block_done) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            acc   <= sum;
            phase <= phase + SHIFT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // out_data is registered so it can hold the last popped value while the FIFO is empty.
    always_comb begin
        head_next = out_data;
        if (do_pop) begin
            if (count > CNT_W'(1)) begin
                head_next = mem[rd_ptr_next];
            end else if (do_push) begin
                head_next = push_data;
            end
        end else if (!out_valid && do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
        end else begin
            out_data <= head_next;
        end
    end

    // A new drop takes priority over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed self-checking bench for fir_decimator (DECIM=4, FIFO_DEPTH=4, DATA_W=16).
module tb_fir_decimator;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] x_in;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        overflow;
    logic        clr_ovf;

    int n_cmp;
    int n_err;

    fir_decimator #(
        .DATA_W    (16),
        .DECIM     (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .x_in     (x_in),
        .flush    (flush),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic signed [15:0] v);
        x_in     = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(2);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_state: valid=%b data=%0d ovf=%b, want 0/0/0", out_valid, out_data, overflow);
        end
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_step;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 3; s++) send(16'sd100);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL step_early%0d: valid=%b, want 0", b, out_valid);
            end
            send(16'sd100);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'd100) begin
                n_err++;
                $display("[TB] FAIL step_out%0d: valid=%b data=%0d, want 1/100", b, out_valid, $signed(out_data));
            end
        end
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd100) begin
            n_err++;
            $display("[TB] FAIL step_drained: valid=%b data=%0d, want 0/100", out_valid, $signed(out_data));
        end
    endtask

    task automatic test_impulse;
        logic signed [15:0] imp [8];
        imp = '{16'sd500, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(imp[i]);
            if (i == 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'd125) begin
                    n_err++;
                    $display("[TB] FAIL impulse_first: valid=%b data=%0d, want 1/125", out_valid, $signed(out_data));
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL impulse_second: valid=%b data=%0d, want 1/0", out_valid, $signed(out_data));
        end
        idle(1);
    endtask

    task automatic test_negative;
        logic signed [15:0] blk [4][4];
        logic signed [15:0] want [4];
        blk  = '{'{-16'sd100, -16'sd100, -16'sd100, -16'sd100},
                 '{-16'sd1, 16'sd0, 16'sd0, 16'sd0},
                 '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767},
                 '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768}};
        want = '{-16'sd100, -16'sd1, 16'sd32767, -16'sd32768};
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 4; s++) send(blk[b][s]);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want[b]) begin
                n_err++;
                $display("[TB] FAIL negative_blk%0d: valid=%b data=%0d, want 1/%0d", b, out_valid, $signed(out_data), want[b]);
            end
        end
        idle(1);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            for (int s = 0; s < 4; s++) send(16'sd7);
            if (b == 3) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL bp_ovf_before: ovf=%b, want 0", overflow);
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'd7) begin
            n_err++;
            $display("[TB] FAIL bp_ovf_after: ovf=%b valid=%b data=%0d, want 1/1/7", overflow, out_valid, $signed(out_data));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'd7) begin
                n_err++;
                $display("[TB] FAIL bp_drain%0d: valid=%b data=%0d, want 1/7", i, out_valid, $signed(out_data));
            end
            idle(1);
        end
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL bp_empty: valid=%b ovf=%b, want 0/1", out_valid, overflow);
        end
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_clr_ovf: ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_full_pop;
        logic [15:0] want [4];
        want = '{16'd2, 16'd3, 16'd4, 16'd9};
        out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            for (int s = 0; s < 4; s++) send(16'(b));
        end
        for (int s = 0; s < 3; s++) send(16'sd9);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd1) begin
            n_err++;
            $display("[TB] FAIL full_hold: valid=%b data=%0d, want 1/1", out_valid, $signed(out_data));
        end
        x_in      = 16'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        idle(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || out_data !== 16'd2) begin
            n_err++;
            $display("[TB] FAIL full_pop_push: ovf=%b data=%0d, want 0/2", overflow, $signed(out_data));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin
                n_err++;
                $display("[TB] FAIL full_drain%0d: valid=%b data=%0d, want 1/%0d", i, out_valid, $signed(out_data), want[i]);
            end
            idle(1);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL full_empty: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_gaps;
        out_ready = 1'b1;
        send(16'sd8);
        idle(1);
        send(16'sd4);
        idle(2);
        send(16'sd12);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL gaps_early: valid=%b, want 0", out_valid);
        end
        send(16'sd0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd6) begin
            n_err++;
            $display("[TB] FAIL gaps_avg: valid=%b data=%0d, want 1/6", out_valid, $signed(out_data));
        end
        idle(1);
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        send(16'sd1000);
        send(16'sd1000);
        flush = 1'b1;
        x_in = 16'd1000;
        in_valid = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) send(16'sd4);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_early: valid=%b, want 0", out_valid);
        end
        send(16'sd8);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd5) begin
            n_err++;
            $display("[TB] FAIL flush_restart: valid=%b data=%0d, want 1/5", out_valid, $signed(out_data));
        end
        idle(1);
        for (int s = 0; s < 3; s++) send(16'sd40);
        flush = 1'b1;
        x_in = 16'd40;
        in_valid = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_no_push: valid=%b, want 0", out_valid);
        end
        for (int s = 0; s < 4; s++) send(16'sd2);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd2) begin
            n_err++;
            $display("[TB] FAIL flush_after_full: valid=%b data=%0d, want 1/2", out_valid, $signed(out_data));
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) send(16'sd11);
        for (int s = 0; s < 3; s++) send(16'sd50);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_mid: valid=%b data=%0d ovf=%b, want 0/0/0", out_valid, $signed(out_data), overflow);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) send(16'sd6);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd6) begin
            n_err++;
            $display("[TB] FAIL reset_clean: valid=%b data=%0d, want 1/6", out_valid, $signed(out_data));
        end
        idle(1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_step();
        test_impulse();
        test_negative();
        test_backpressure();
        test_full_pop();
        test_gaps();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
